// File: rtl/uart_baud_tick_gen.sv
// rtl/uart_baud_tick_gen.sv - programmable UART baud tick generator
// Start/stop handshake, per-run divisor latch, optional half first period, counted auto-stop.
module uart_baud_tick_gen #(
  parameter int CNT_W   = 18,
  parameter int NTICK_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [CNT_W-1:0]   divisor,
  input  logic               half_first,
  input  logic [NTICK_W-1:0] ntick,
  output logic               tick,
  output logic [NTICK_W-1:0] tick_idx,
  output logic               busy,
  output logic               done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   div_q, div_d;
  logic               half_q, half_d;
  logic               first_q, first_d;
  logic [NTICK_W-1:0] ntick_q, ntick_d;
  logic [NTICK_W-1:0] tcnt_q, tcnt_d;
  logic [NTICK_W-1:0] idx_q, idx_d;
  logic               tick_q, tick_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   period_m1;
  logic               last_tick;

  // Only the very first period of a run may be halved.
  assign period_m1 = ((first_q && half_q) ? (div_q >> 1) : div_q) - CNT_W'(1);
  assign last_tick = (ntick_q != '0) && (tcnt_q == ntick_q - NTICK_W'(1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    half_d  = half_q;
    first_d = first_q;
    ntick_d = ntick_q;
    tcnt_d  = tcnt_q;
    idx_d   = idx_q;
    tick_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = RUN;
          div_d   = (divisor < CNT_W'(2)) ? CNT_W'(2) : divisor;
          half_d  = half_first;
          ntick_d = ntick;
          first_d = 1'b1;
          cnt_d   = '0;
          tcnt_d  = '0;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == period_m1) begin
          cnt_d   = '0;
          tick_d  = 1'b1;
          idx_d   = tcnt_q;
          tcnt_d  = tcnt_q + NTICK_W'(1);
          first_d = 1'b0;
          if (last_tick) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      half_q  <= 1'b0;
      first_q <= 1'b0;
      ntick_q <= '0;
      tcnt_q  <= '0;
      idx_q   <= '0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      half_q  <= half_d;
      first_q <= first_d;
      ntick_q <= ntick_d;
      tcnt_q  <= tcnt_d;
      idx_q   <= idx_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
    end
  end

  assign tick     = tick_q;
  assign tick_idx = idx_q;
  assign done     = done_q;
  assign busy     = (state_q == RUN);

endmodule

// File: tb/tb_uart_baud_tick_gen.sv
// tb/tb_uart_baud_tick_gen.sv - scoreboard bench for uart_baud_tick_gen
module tb_uart_baud_tick_gen;
  localparam int CNT_W   = 18;
  localparam int NTICK_W = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               stop;
  logic [CNT_W-1:0]   divisor;
  logic               half_first;
  logic [NTICK_W-1:0] ntick;
  logic               tick;
  logic [NTICK_W-1:0] tick_idx;
  logic               busy;
  logic               done;

  uart_baud_tick_gen #(.CNT_W(CNT_W), .NTICK_W(NTICK_W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .divisor(divisor),
    .half_first(half_first), .ntick(ntick), .tick(tick), .tick_idx(tick_idx),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int e;
    int idx;
    int dn;
  } exp_t;
  exp_t sb[$];
  exp_t mx;

  task automatic check_eq(input string tag, input int obs, input int expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_until(input int e);
    while (edge_n < e) step();
  endtask

  task automatic start_run(input int d, input bit h, input int n, input int cnt, output int e0);
    int dc, p0;
    divisor = CNT_W'(d);
    half_first = h;
    ntick = NTICK_W'(n);
    start = 1'b1;
    step();
    start = 1'b0;
    e0 = edge_n;
    dc = (d < 2) ? 2 : d;
    p0 = h ? (dc >> 1) : dc;
    for (int k = 0; k < cnt; k++) begin
      exp_t x;
      x.e = e0 + p0 + k * dc;
      x.idx = k % (1 << NTICK_W);
      x.dn = (n != 0 && k == n - 1) ? 1 : 0;
      sb.push_back(x);
    end
  endtask

  always @(negedge clk) begin
    if (tick) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_tick_edge", edge_n, -1);
      end else begin
        mx = sb.pop_front();
        check_eq("tick_edge", edge_n, mx.e);
        check_eq("tick_idx", int'(tick_idx), mx.idx);
        check_eq("tick_done", int'(done), mx.dn);
      end
    end else if (done) begin
      check_eq("done_without_tick", 1, 0);
    end
  end

  initial begin
    int e0, e1;
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    divisor = '0; half_first = 1'b0; ntick = '0;
    step(); step();
    check_eq("rst_tick", int'(tick), 0);
    check_eq("rst_idx", int'(tick_idx), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_done", int'(done), 0);
    rst = 1'b0;

    // Counted run: D=4, three ticks.
    repeat (9) step();
    start_run(4, 1'b0, 3, 3, e0);
    check_eq("s1_busy_e0", int'(busy), 1);
    while (edge_n < e0 + 14) begin
      step();
      check_eq("s1_busy", int'(busy), (edge_n < e0 + 12) ? 1 : 0);
    end

    // Half-first: D=5 gives ticks at +2 and +7.
    start_run(5, 1'b1, 2, 2, e0);
    step_until(e0 + 9);
    check_eq("s2_busy_end", int'(busy), 0);

    // Clamp to 2 and free-run, index wraps; stop lands on a due tick.
    start_run(0, 1'b0, 0, 20, e0);
    step_until(e0 + 41);
    check_eq("s3_busy_run", int'(busy), 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check_eq("s3_busy_stop", int'(busy), 0);
    repeat (4) step();

    // Ignored restart with a different divisor, then stop on the second tick.
    start_run(8, 1'b0, 5, 1, e0);
    step_until(e0 + 2);
    divisor = CNT_W'(3);
    ntick = NTICK_W'(1);
    start = 1'b1;
    step();
    start = 1'b0;
    check_eq("s4_busy_restart", int'(busy), 1);
    step_until(e0 + 15);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check_eq("s4_busy_stop", int'(busy), 0);
    repeat (10) step();
    check_eq("s4_busy_after", int'(busy), 0);

    // Reset mid-run.
    start_run(6, 1'b0, 4, 1, e0);
    step_until(e0 + 8);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("s5_rst_tick", int'(tick), 0);
    check_eq("s5_rst_idx", int'(tick_idx), 0);
    check_eq("s5_rst_busy", int'(busy), 0);
    check_eq("s5_rst_done", int'(done), 0);
    step_until(e0 + 14);
    check_eq("s5_busy_after", int'(busy), 0);

    // Back-to-back: restart in the done cycle.
    start_run(3, 1'b0, 1, 1, e0);
    step_until(e0 + 3);
    check_eq("s6_busy_done", int'(busy), 0);
    start_run(3, 1'b0, 1, 1, e1);
    check_eq("s6_accept_edge", e1, e0 + 4);
    check_eq("s6_busy_second", int'(busy), 1);
    step_until(e1 + 5);
    check_eq("s6_busy_end", int'(busy), 0);

    check_eq("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
